// File: rtl/video_timing_gen_param.sv
// Parametrised progressive video timing generator: hsync/vsync/de, pixel coordinates,
// start-of-frame and end-of-line markers, with frame-aligned start and stop.
module video_timing_gen_param #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 13
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             sof,
  output logic             eol,
  output logic             busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_EOL    = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             h_wrap, frame_end, running;

  assign h_wrap    = (hcnt_q == H_LAST);
  assign frame_end = h_wrap && (vcnt_q == V_LAST);
  assign running   = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    case (state_q)
      S_IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (enable) state_d = S_RUN;
      end
      S_RUN, S_STOP: begin
        if (h_wrap) begin
          hcnt_d = '0;
          vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_ONE;
        end else begin
          hcnt_d = hcnt_q + CNT_ONE;
        end
        // A stop request lets the current frame finish; re-enabling before then resumes seamlessly.
        if (state_q == S_RUN) begin
          if (!enable) state_d = S_STOP;
        end else if (enable) begin
          state_d = S_RUN;
        end else if (frame_end) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  // Outputs decode the current state/counters and are registered, so they trail by one edge.
  logic             hs_win, vs_win, h_act, v_act;
  logic             hsync_d, vsync_d, de_d, sof_d, eol_d;
  logic [CNT_W-1:0] x_d, y_d;

  always_comb begin
    hs_win  = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    vs_win  = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
    h_act   = (hcnt_q < H_ACT);
    v_act   = (vcnt_q < V_ACT);
    hsync_d = (running && hs_win) ? HS_POL : ~HS_POL;
    vsync_d = (running && vs_win) ? VS_POL : ~VS_POL;
    de_d    = running && h_act && v_act;
    sof_d   = running && (hcnt_q == '0) && (vcnt_q == '0);
    eol_d   = running && (hcnt_q == H_EOL) && v_act;
    x_d     = running ? hcnt_q : '0;
    y_d     = running ? vcnt_q : '0;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      de    <= 1'b0;
      sof   <= 1'b0;
      eol   <= 1'b0;
      x     <= '0;
      y     <= '0;
      busy  <= 1'b0;
    end else begin
      hsync <= hsync_d;
      vsync <= vsync_d;
      de    <= de_d;
      sof   <= sof_d;
      eol   <= eol_d;
      x     <= x_d;
      y     <= y_d;
      busy  <= running;
    end
  end

endmodule

// File: tb/tb_video_timing_gen_param.sv
// Bench for video_timing_gen_param: small 16x8 format, one active-high and one
// active-low sync instance checked every cycle against a reference model.
module tb_video_timing_gen_param;
  localparam int CW = 5;
  localparam int W  = 32;

  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;

  logic hsync_p, vsync_p, de_p, sof_p, eol_p, busy_p;
  logic [CW-1:0] x_p, y_p;
  logic hsync_n, vsync_n, de_n, sof_n, eol_n, busy_n;
  logic [CW-1:0] x_n, y_n;

  video_timing_gen_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW)
  ) dut (
    .pclk(pclk), .rst(rst), .enable(enable),
    .hsync(hsync_p), .vsync(vsync_p), .de(de_p), .x(x_p), .y(y_p),
    .sof(sof_p), .eol(eol_p), .busy(busy_p)
  );

  video_timing_gen_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW)
  ) dut_n (
    .pclk(pclk), .rst(rst), .enable(enable),
    .hsync(hsync_n), .vsync(vsync_n), .de(de_n), .x(x_n), .y(y_n),
    .sof(sof_n), .eol(eol_n), .busy(busy_n)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: 0 idle, 1 run, 2 stop
  int m_state = 0;
  int m_h = 0;
  int m_v = 0;

  // Whole-frame statistics gathered from DUT outputs between consecutive sof pulses
  bit have_prev = 1'b0;
  bit gap = 1'b1;
  bit seen_idle = 1'b0;
  int prev_sof = 0;
  int eol_cnt = 0, de_cnt = 0, hs_cnt = 0, vs_cnt = 0, hsn_low = 0, vsn_low = 0;

  typedef struct {
    bit r;
    bit e;
    int n;
    int ex;
    int ey;
    bit eb;
    bit ede;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] pack_exp(input bit act, input int h, input int v, input bit pol);
    bit hs, vs, d, s, e;
    if (!act) return {1'b0, ~pol, ~pol, 3'b000, 10'd0};
    hs = (h >= 10) && (h < 13);
    vs = (v >= 5) && (v < 7);
    d  = (h < 8) && (v < 4);
    s  = (h == 0) && (v == 0);
    e  = (h == 7) && (v < 4);
    return {1'b1, hs ? pol : ~pol, vs ? pol : ~pol, d, s, e, 5'(h), 5'(v)};
  endfunction

  function automatic logic [W-1:0] pack_act();
    return {busy_p, hsync_p, vsync_p, de_p, sof_p, eol_p, x_p, y_p,
            busy_n, hsync_n, vsync_n, de_n, sof_n, eol_n, x_n, y_n};
  endfunction

  task automatic step(input bit r, input bit e);
    logic [W-1:0] exp_w;
    bit act, fend;
    @(negedge pclk);
    rst = r;
    enable = e;
    act = !r && (m_state != 0);
    exp_q.push_back({pack_exp(act, m_h, m_v, 1'b1), pack_exp(act, m_h, m_v, 1'b0)});
    if (r) begin
      m_state = 0; m_h = 0; m_v = 0;
    end else if (m_state == 0) begin
      if (e) m_state = 1;
    end else begin
      fend = (m_h == 15) && (m_v == 7);
      m_h = m_h + 1;
      if (m_h == 16) begin
        m_h = 0;
        m_v = (m_v + 1) % 8;
      end
      if (m_state == 1) begin
        if (!e) m_state = 2;
      end else if (e) m_state = 1;
      else if (fend) m_state = 0;
    end
    @(posedge pclk);
    #1;
    cyc++;
    exp_w = exp_q.pop_front();
    check("cycle_outputs", pack_act(), exp_w);
    if (busy_p !== 1'b1) begin
      gap = 1'b1;
      seen_idle = 1'b1;
    end
    if (sof_p === 1'b1) begin
      if (have_prev && !gap) begin
        check("sof_period", cyc - prev_sof, 128);
        check("eol_per_frame", eol_cnt, 4);
        check("de_per_frame", de_cnt, 32);
        check("hsync_hi_per_frame", hs_cnt, 24);
        check("vsync_hi_per_frame", vs_cnt, 32);
        check("hsync_n_lo_per_frame", hsn_low, 24);
        check("vsync_n_lo_per_frame", vsn_low, 32);
      end
      have_prev = 1'b1;
      gap = 1'b0;
      prev_sof = cyc;
      eol_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; hsn_low = 0; vsn_low = 0;
    end
    eol_cnt += (eol_p === 1'b1) ? 1 : 0;
    de_cnt  += (de_p === 1'b1) ? 1 : 0;
    hs_cnt  += (hsync_p === 1'b1) ? 1 : 0;
    vs_cnt  += (vsync_p === 1'b1) ? 1 : 0;
    hsn_low += (hsync_n === 1'b0) ? 1 : 0;
    vsn_low += (vsync_n === 1'b0) ? 1 : 0;
  endtask

  initial begin
    // Continuous run, then a stop request mid-frame that drains to idle
    tbl[0] = '{r: 1'b1, e: 1'b0, n: 3,   ex: 0,  ey: 0, eb: 1'b0, ede: 1'b0};
    tbl[1] = '{r: 1'b0, e: 1'b1, n: 2,   ex: 0,  ey: 0, eb: 1'b1, ede: 1'b1};
    tbl[2] = '{r: 1'b0, e: 1'b1, n: 10,  ex: 10, ey: 0, eb: 1'b1, ede: 1'b0};
    tbl[3] = '{r: 1'b0, e: 1'b1, n: 20,  ex: 14, ey: 1, eb: 1'b1, ede: 1'b0};
    tbl[4] = '{r: 1'b0, e: 1'b1, n: 100, ex: 2,  ey: 0, eb: 1'b1, ede: 1'b1};
    tbl[5] = '{r: 1'b0, e: 1'b0, n: 1,   ex: 3,  ey: 0, eb: 1'b1, ede: 1'b1};
    tbl[6] = '{r: 1'b0, e: 1'b0, n: 124, ex: 15, ey: 7, eb: 1'b1, ede: 1'b0};
    tbl[7] = '{r: 1'b0, e: 1'b0, n: 1,   ex: 0,  ey: 0, eb: 1'b0, ede: 1'b0};
    tbl[8] = '{r: 1'b0, e: 1'b0, n: 5,   ex: 0,  ey: 0, eb: 1'b0, ede: 1'b0};

    for (int i = 0; i < 9; i++) begin
      repeat (tbl[i].n) step(tbl[i].r, tbl[i].e);
      check($sformatf("tbl%0d_x", i), x_p, tbl[i].ex);
      check($sformatf("tbl%0d_y", i), y_p, tbl[i].ey);
      check($sformatf("tbl%0d_busy", i), busy_p, tbl[i].eb);
      check($sformatf("tbl%0d_de", i), de_p, tbl[i].ede);
    end

    // Drop enable on line 2, re-raise on line 5: no gap, next sof 128 cycles later
    repeat (2) step(1'b0, 1'b1);
    check("restart_sof", sof_p, 1);
    seen_idle = 1'b0;
    repeat (32) step(1'b0, 1'b1);
    check("drop_at_y2", y_p, 2);
    repeat (48) step(1'b0, 1'b0);
    check("raise_at_y5", y_p, 5);
    repeat (48) step(1'b0, 1'b1);
    check("resume_sof", sof_p, 1);
    check("resume_busy_held", seen_idle, 0);

    // Reset in the middle of an active line
    repeat (20) step(1'b0, 1'b1);
    check("pre_rst_x", x_p, 4);
    check("pre_rst_y", y_p, 1);
    check("pre_rst_de", de_p, 1);
    step(1'b1, 1'b1);
    check("rst_de", de_p, 0);
    check("rst_xy", {x_p, y_p}, 0);
    check("rst_busy", busy_p, 0);
    check("rst_syncs_hi_pol", {hsync_p, vsync_p}, 2'b00);
    check("rst_syncs_lo_pol", {hsync_n, vsync_n}, 2'b11);

    // Full frame after restart, then drain to idle
    repeat (2) step(1'b0, 1'b1);
    check("post_rst_sof", sof_p, 1);
    repeat (128) step(1'b0, 1'b1);
    check("post_rst_second_sof", sof_p, 1);
    repeat (140) step(1'b0, 1'b0);
    check("final_busy", busy_p, 0);
    check("final_idle_syncs_lo_pol", {hsync_n, vsync_n}, 2'b11);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
